// File: rtl/jogador_automatico_if.sv
// Game-side <-> automatic-player signal bundle for the Genius datapath.
// master = game/datapath side, slave = automatic player.
interface jogador_automatico_if;
  logic       habilita;
  logic       limpa;
  logic [3:0] leds;
  logic       mostrando;
  logic       vez_jogador;
  logic [3:0] botoes;
  logic       ocupado;
  logic       fim_replay;
  logic       transbordo;
  logic       invalido;
  logic [4:0] db_tamanho;
  logic [2:0] db_estado;

  modport master (
    output habilita, limpa, leds, mostrando, vez_jogador,
    input  botoes, ocupado, fim_replay, transbordo, invalido, db_tamanho, db_estado
  );

  modport slave (
    input  habilita, limpa, leds, mostrando, vez_jogador,
    output botoes, ocupado, fim_replay, transbordo, invalido, db_tamanho, db_estado
  );
endinterface

// File: rtl/jogador_automatico.sv
// Automatic Genius player: records the LED show into a buffer and replays it
// as timed button presses when the game hands the turn to the player.
module jogador_automatico #(
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input logic                 clock,
  input logic                 reset,
  jogador_automatico_if.slave jog
);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    PRESSIONA = 3'd1,
    SOLTA     = 3'd2,
    FIM       = 3'd3
  } estado_t;

  estado_t       estado;
  logic [3:0]    buffer [DEPTH];
  logic [4:0]    tamanho;
  logic [AW-1:0] rd;
  logic [CW-1:0] cnt;
  logic          mostrando_q;
  logic          vez_q;
  logic [3:0]    botoes_r;
  logic          ocupado_r;
  logic          fim_r;
  logic          transbordo_r;
  logic          invalido_r;

  logic captura;
  logic inicio;
  logic cheio;
  logic um_quente;

  always_comb begin
    captura   = (estado == OCIOSO) && jog.habilita && jog.mostrando && !mostrando_q;
    inicio    = (estado == OCIOSO) && jog.habilita && jog.vez_jogador && !vez_q;
    cheio     = (tamanho == 5'(DEPTH));
    um_quente = (jog.leds != 4'd0) && ((jog.leds & (jog.leds - 4'd1)) == 4'd0);
  end

  always_ff @(posedge clock) begin
    if (reset || jog.limpa) begin
      estado       <= OCIOSO;
      tamanho      <= '0;
      rd           <= '0;
      cnt          <= '0;
      mostrando_q  <= 1'b0;
      vez_q        <= 1'b0;
      botoes_r     <= '0;
      ocupado_r    <= 1'b0;
      fim_r        <= 1'b0;
      transbordo_r <= 1'b0;
      invalido_r   <= 1'b0;
    end else begin
      mostrando_q <= jog.mostrando;
      vez_q       <= jog.vez_jogador;
      fim_r       <= 1'b0;

      if (captura) begin
        if (cheio) begin
          transbordo_r <= 1'b1;
        end else begin
          buffer[tamanho[AW-1:0]] <= jog.leds;
          tamanho                 <= tamanho + 5'd1;
          if (!um_quente) invalido_r <= 1'b1;
        end
      end

      if (!jog.habilita && estado != OCIOSO) begin
        estado    <= OCIOSO;
        botoes_r  <= '0;
        ocupado_r <= 1'b0;
      end else begin
        case (estado)
          OCIOSO: begin
            if (inicio) begin
              if (tamanho == 5'd0 && !captura) begin
                estado <= FIM;
                fim_r  <= 1'b1;
              end else begin
                estado    <= PRESSIONA;
                ocupado_r <= 1'b1;
                rd        <= '0;
                cnt       <= '0;
                // A capture on this same edge lands in entry 0 only next cycle: forward it
                botoes_r  <= (captura && tamanho == 5'd0) ? jog.leds : buffer[0];
              end
            end
          end
          PRESSIONA: begin
            if (cnt == CW'(HOLD_CYCLES - 1)) begin
              estado   <= SOLTA;
              botoes_r <= '0;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SOLTA: begin
            if (cnt == CW'(GAP_CYCLES - 1)) begin
              cnt <= '0;
              if (5'(rd) == tamanho - 5'd1) begin
                estado    <= FIM;
                ocupado_r <= 1'b0;
                fim_r     <= 1'b1;
              end else begin
                estado   <= PRESSIONA;
                rd       <= rd + 1'b1;
                botoes_r <= buffer[rd + 1'b1];
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          FIM:     estado <= OCIOSO;
          default: estado <= OCIOSO;
        endcase
      end
    end
  end

  assign jog.botoes     = botoes_r;
  assign jog.ocupado    = ocupado_r;
  assign jog.fim_replay = fim_r;
  assign jog.transbordo = transbordo_r;
  assign jog.invalido   = invalido_r;
  assign jog.db_tamanho = tamanho;
  assign jog.db_estado  = estado;
endmodule

// File: tb/tb_jogador_automatico.sv
// Scoreboard bench for jogador_automatico: drivers push expected presses and
// replay ends into queues; a negedge monitor pops and compares them.
module tb_jogador_automatico;
  localparam int HOLD = 4;
  localparam int GAP  = 4;
  localparam int DEP  = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  jogador_automatico_if jif ();

  jogador_automatico #(.DEPTH(DEP), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clock (clock),
    .reset (reset),
    .jog   (jif.slave)
  );

  typedef struct {
    bit         fim;
    logic [3:0] val;
    int         lat;
  } ev_t;

  ev_t        exp_q[$];
  int         ocup_q[$];
  logic [3:0] model[$];
  bit         m_transb, m_inval;
  int         n_chk = 0, n_fail = 0;
  int         cyc = 0, vez_cyc = 0, fim_seen = 0, fim_any = 0;
  bit         mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor
  logic [3:0] prev_b = '0;
  bit         prev_ocup = 1'b0, had_press = 1'b0;
  int         hold = 0, gap = 0, ocup_len = 0;

  always @(negedge clock) begin
    ev_t e;
    if (jif.fim_replay) fim_any++;
    if (!mon_en) begin
      prev_b = '0; prev_ocup = 1'b0; had_press = 1'b0;
      hold = 0; gap = 0; ocup_len = 0;
    end else begin
      if (jif.botoes != 4'd0 && prev_b == 4'd0) begin
        if (had_press) check("gap_len", gap, GAP);
        if (exp_q.size() == 0) check("spurious_press", int'(jif.botoes), 0);
        else begin
          e = exp_q.pop_front();
          check("press_is_fim", int'(e.fim), 0);
          check("press_val", int'(jif.botoes), int'(e.val));
          if (e.lat >= 0) check("press_latency", cyc - vez_cyc, e.lat);
        end
        had_press = 1'b1; gap = 0; hold = 0;
      end
      if (jif.botoes != 4'd0) hold++;
      else begin
        if (prev_b != 4'd0) check("hold_len", hold, HOLD);
        if (jif.ocupado) gap++;
      end
      if (jif.fim_replay) begin
        fim_seen++;
        if (exp_q.size() == 0) check("spurious_fim", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("fim_kind", int'(e.fim), 1);
          if (e.lat >= 0) check("fim_latency", cyc - vez_cyc, e.lat);
        end
        if (had_press) check("last_gap", gap, GAP);
        had_press = 1'b0;
      end
      if (jif.ocupado) ocup_len++;
      else if (prev_ocup) begin
        if (ocup_q.size() == 0) check("spurious_ocupado", ocup_len, 0);
        else check("ocupado_len", ocup_len, ocup_q.pop_front());
        ocup_len = 0;
      end
      prev_b = jif.botoes; prev_ocup = jif.ocupado;
    end
  end

  // Drivers
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic model_capture(input logic [3:0] v);
    if (model.size() < DEP) begin
      model.push_back(v);
      if ($countones(v) != 1) m_inval = 1'b1;
    end else m_transb = 1'b1;
  endtask

  task automatic show(input logic [3:0] v);
    jif.leds = v; jif.mostrando = 1'b1;
    tick(); tick();
    jif.mostrando = 1'b0;
    tick(); tick();
    model_capture(v);
  endtask

  task automatic do_limpa();
    jif.limpa = 1'b1; tick(); jif.limpa = 1'b0;
    model.delete(); m_transb = 1'b0; m_inval = 1'b0;
  endtask

  task automatic status(input string tag);
    check({tag, "_db_tamanho"}, int'(jif.db_tamanho), model.size());
    check({tag, "_transbordo"}, int'(jif.transbordo), int'(m_transb));
    check({tag, "_invalido"}, int'(jif.invalido), int'(m_inval));
  endtask

  // with_show: a show pulse rises together with vez_jogador; noise: a show pulse mid-replay
  task automatic replay(input bit with_show, input logic [3:0] v, input bit noise);
    int target;
    if (with_show) model_capture(v);
    for (int i = 0; i < model.size(); i++)
      exp_q.push_back('{fim: 1'b0, val: model[i], lat: (i == 0) ? 1 : -1});
    exp_q.push_back('{fim: 1'b1, val: 4'd0, lat: (model.size() == 0) ? 1 : -1});
    if (model.size() > 0) ocup_q.push_back((HOLD + GAP) * model.size());
    target = fim_seen + 1;
    if (with_show) begin jif.leds = v; jif.mostrando = 1'b1; end
    jif.vez_jogador = 1'b1; vez_cyc = cyc;
    tick(); tick();
    jif.vez_jogador = 1'b0; jif.mostrando = 1'b0;
    if (noise) begin
      tick(); jif.leds = 4'b1111; jif.mostrando = 1'b1;
      tick(); tick(); jif.mostrando = 1'b0;
    end
    for (int k = 0; k < 1000 && fim_seen < target; k++) tick();
    if (fim_seen < target) check("replay_timeout", 0, 1);
    tick(); tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq4 [4];
    int f0;
    jif.habilita = 1'b1; jif.limpa = 1'b0; jif.leds = '0;
    jif.mostrando = 1'b0; jif.vez_jogador = 1'b0;
    m_transb = 1'b0; m_inval = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_botoes", int'(jif.botoes), 0);
    check("rst_ocupado", int'(jif.ocupado), 0);
    check("rst_fim", int'(jif.fim_replay), 0);
    check("rst_estado", int'(jif.db_estado), 0);
    status("rst");
    mon_en = 1'b1;

    // single press, with a mostrando pulse mid-replay that must be ignored
    show(4'b0010); status("t1");
    replay(1'b0, 4'd0, 1'b1); status("t1_after");

    // three presses
    do_limpa();
    show(4'b0001); show(4'b0100); show(4'b1000); status("t2");
    replay(1'b0, 4'd0, 1'b0);

    // overflow
    do_limpa();
    for (int i = 0; i < 17; i++) show(4'b0001 << (i % 4));
    status("t3"); check("t3_transbordo_set", int'(jif.transbordo), 1);
    replay(1'b0, 4'd0, 1'b0);

    // empty replay
    do_limpa();
    replay(1'b0, 4'd0, 1'b0);

    // non one-hot capture
    do_limpa();
    show(4'b0011); status("t5"); check("t5_invalido_set", int'(jif.invalido), 1);
    replay(1'b0, 4'd0, 1'b0);

    // reset during PRESSIONA
    mon_en = 1'b0;
    jif.vez_jogador = 1'b1; tick(); jif.vez_jogador = 1'b0;
    check("t5_in_pressiona", int'(jif.db_estado), 1);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    model.delete(); m_transb = 1'b0; m_inval = 1'b0;
    check("t5_rst_botoes", int'(jif.botoes), 0);
    check("t5_rst_tamanho", int'(jif.db_tamanho), 0);
    check("t5_rst_estado", int'(jif.db_estado), 0);
    check("t5_rst_ocupado", int'(jif.ocupado), 0);
    tick(); mon_en = 1'b1;

    // simultaneous show and vez_jogador edge with empty buffer
    replay(1'b1, 4'b0100, 1'b0); status("t6");

    // habilita dropped mid-replay
    show(4'b0001); status("t7");
    mon_en = 1'b0;
    f0 = fim_any;
    jif.vez_jogador = 1'b1; tick(); jif.vez_jogador = 1'b0; tick(); tick();
    jif.habilita = 1'b0; tick();
    check("t7_botoes_off", int'(jif.botoes), 0);
    check("t7_estado_ocioso", int'(jif.db_estado), 0);
    check("t7_ocupado_off", int'(jif.ocupado), 0);
    for (int i = 0; i < 12; i++) tick();
    check("t7_no_fim", fim_any - f0, 0);
    jif.habilita = 1'b1; tick(); status("t7_kept");
    mon_en = 1'b1; tick();
    replay(1'b0, 4'd0, 1'b0);

    // four growing rounds
    seq4[0] = 4'b1000; seq4[1] = 4'b0001; seq4[2] = 4'b0010; seq4[3] = 4'b0100;
    for (int r = 1; r <= 4; r++) begin
      do_limpa();
      for (int i = 0; i < r; i++) show(seq4[i]);
      replay(1'b0, 4'd0, 1'b0);
    end

    tick(); tick();
    check("exp_queue_drained", exp_q.size(), 0);
    check("ocup_queue_drained", ocup_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
